mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and sequences a fixed-latency busy window. It commits results to the architectural HI/LO registers and raises a stall request that the hazard unit ORs into its global stall. It sits beside the E-stage ALU and is fed with already-forwarded rs/rt operand values.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  E-stage instruction is an MDU operation; qualifies md_op
md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
rs_val  input  32  forwarded rs operand (E stage)
rt_val  input  32  forwarded rt operand (E stage)
md_D  input  1  D-stage instruction uses the MDU (mult/div/mthi/mtlo/mfhi/mflo)
busy  output  1  operation in progress
stall_md  output  1  stall request to the hazard unit
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset: state IDLE, counter 0, busy 0, hi 0, lo 0, captured operands 0.
- States: IDLE and BUSY. busy is 1 exactly when state is BUSY (registered output).
- IDLE, start and md_op in 0..3:
  - Capture rs_val, rt_val and md_op.
  - Load the counter with MULT_CYCLES (ops 0,1) or DIV_CYCLES (ops 2,3).
  - Go to BUSY.
- IDLE, start and md_op 4: hi <= rs_val on that edge; stay IDLE.
- IDLE, start and md_op 5: lo <= rs_val on that edge; stay IDLE.
- start with md_op 6..7: no effect.
- BUSY: the counter decrements each cycle.
  - When the counter is 1, on that edge commit the result to hi/lo, clear the counter and go to IDLE.
  - busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - New hi/lo are visible in the first cycle busy is 0.
- start while BUSY: ignored. The hazard unit guarantees this cannot occur; the bench checks it is harmless.
- Results, computed from the captured operands only:
  - MULT: signed 64-bit product; hi = [63:32], lo = [31:0].
  - MULTU: unsigned 64-bit product; same split.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (rs).
  - DIVU: unsigned quotient to lo, remainder to hi.
  - Divisor 0 (DIV/DIVU): the busy window runs normally; hi and lo are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- stall_md = md_D && (busy || (start && md_op <= 3)). This is combinational; no registered latency is allowed.
- Reset asserted mid-operation: the in-flight result is discarded, and all state returns to reset values on that edge.
- The E-stage flush/bubble path must deassert start. The controller has no flush input.

Decomposition:
- Shared package mdu_defs:
  - md_op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
  - State encodings: ST_IDLE, ST_BUSY.
  - Default cycle constants.
- One sub-module, mdu_arith: purely combinational.
  - Inputs: captured op, a, b.
  - Outputs: 64-bit {hi_res, lo_res} and a div_zero flag.
- mdu_ctrl keeps the FSM, counter, HI/LO registers and stall logic.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat with MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=0 with prior hi=0x11, lo=0x22 -> busy 10 cycles, hi/lo stay 0x11/0x22.
- MTHI rs=0xDEADBEEF while idle -> hi=0xDEADBEEF next cycle, busy stays 0. MTLO rs=0x12345678 -> lo=0x12345678.
- md_D=1 in the same cycle as start=1, md_op=MULT -> stall_md=1 that cycle and all 5 busy cycles; stall_md=0 first cycle after busy falls. md_D=1 while idle with start=0 -> stall_md=0.
- Start DIV, assert reset at busy cycle 4 -> busy=0, hi=lo=0 next cycle; no later commit occurs.
- During MULT busy, pulse start with md_op=MTHI, rs=0xAAAAAAAA -> ignored; the final hi/lo equal the MULT result only.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op encodings,
// FSM state encodings and default busy-window lengths.
package mdu_defs;

  localparam int CNT_W           = 4;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Ops that open a busy window (multiply and divide variants).
  function automatic logic is_long_op(input logic [2:0] op);
    return (op <= 3'd3);
  endfunction

endpackage

// File: rtl/mdu_ctrl_arith.sv
// Combinational multiply/divide datapath working on the captured operands.
// Results are presented as {hi_res, lo_res}; div_zero flags a zero divisor.
module mdu_arith
  import mdu_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        div_zero
);

  logic        is_div;
  logic        is_signed_div;
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic [31:0] num;
  logic [31:0] den;
  logic [31:0] den_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_res;
  logic [31:0] r_res;

  always_comb begin
    is_div        = (op == MD_DIV) || (op == MD_DIVU);
    is_signed_div = (op == MD_DIV);
    div_zero      = is_div && (b == 32'd0);

    prod_u = {32'd0, a} * {32'd0, b};
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});

    // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    num      = (is_signed_div && a[31]) ? (32'd0 - a) : a;
    den      = (is_signed_div && b[31]) ? (32'd0 - b) : b;
    den_safe = (den == 32'd0) ? 32'd1 : den;
    q_mag    = num / den_safe;
    r_mag    = num % den_safe;

    q_res = q_mag;
    r_res = r_mag;
    if (is_signed_div) begin
      if (a[31] ^ b[31]) q_res = 32'd0 - q_mag;
      if (a[31])         r_res = 32'd0 - r_mag;
    end

    hi_res = 32'd0;
    lo_res = 32'd0;
    case (op)
      MD_MULT:           {hi_res, lo_res} = prod_s;
      MD_MULTU:          {hi_res, lo_res} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi_res = r_res;
        lo_res = q_res;
      end
      default: begin
        hi_res = 32'd0;
        lo_res = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV controller beside the E-stage ALU: runs a fixed-length
// busy window, commits HI/LO at its end, and requests a pipeline stall.
module mdu_ctrl
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  logic               start_long;
  logic               last_cycle;
  logic [31:0]        hi_res;
  logic [31:0]        lo_res;
  logic               div_zero;

  mdu_arith u_arith (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  assign start_long = start && is_long_op(md_op);
  assign last_cycle = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_long) state_d = ST_BUSY;
      ST_BUSY: if (last_cycle) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; stall must react in the same cycle the op is issued.
  always_comb begin
    busy     = (state_q == ST_BUSY);
    stall_md = md_D && (busy || start_long);
    hi       = hi_q;
    lo       = lo_q;
  end

  // Datapath: operand capture, countdown, HI/LO writes
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (state_q == ST_IDLE) begin
      if (start_long) begin
        op_d  = md_op;
        a_d   = rs_val;
        b_d   = rt_val;
        cnt_d = (md_op <= MD_MULTU) ? MULT_CNT : DIV_CNT;
      end else if (start && (md_op == MD_MTHI)) begin
        hi_d = rs_val;
      end else if (start && (md_op == MD_MTLO)) begin
        lo_d = rs_val;
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      // A zero divisor still consumes the window but leaves HI/LO alone.
      if (last_cycle && !div_zero) begin
        hi_d = hi_res;
        lo_d = lo_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule
